// File: rtl/framebuffer_pkg.sv
// -----------------------------------------------------------------------------
// framebuffer_pkg
// Shared types for the double-buffered framebuffer.
//   fb_state_t : controller state (normal operation / clearing the back bank)
// The write-pipeline stage record (valid, addr, data) is declared inside
// fb_write_pipe, because its field widths follow that module's parameters.
// -----------------------------------------------------------------------------
package framebuffer_pkg;

    typedef enum logic {
        FB_IDLE     = 1'b0,
        FB_CLEARING = 1'b1
    } fb_state_t;

endpackage

// File: rtl/bram_dp.sv
// -----------------------------------------------------------------------------
// bram_dp
// Simple dual-port block RAM: port A writes, port B reads with 1-cycle latency.
// Read-during-write to the same address on a shared clock returns the old data.
// Ports:
//   i_clk_a, i_we_a, i_addr_a, i_din_a : write port
//   i_clk_b, i_addr_b, o_dout_b        : registered read port
// -----------------------------------------------------------------------------
module bram_dp #(
    parameter int    ADDR_WIDTH = 4,
    parameter int    DATA_WIDTH = 8,
    parameter int    DEPTH      = 16,
    parameter string INIT_FILE  = ""
) (
    input  logic                  i_clk_a,
    input  logic                  i_we_a,
    input  logic [ADDR_WIDTH-1:0] i_addr_a,
    input  logic [DATA_WIDTH-1:0] i_din_a,
    input  logic                  i_clk_b,
    input  logic [ADDR_WIDTH-1:0] i_addr_b,
    output logic [DATA_WIDTH-1:0] o_dout_b
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // NOTE: memory arrays get no reset; a reset loop would turn the RAM into
    // flops. Contents are defined by an explicit clear.
    always_ff @(posedge i_clk_a) begin
        if (i_we_a) begin
            r_mem[i_addr_a] <= i_din_a;
        end
    end

    always_ff @(posedge i_clk_b) begin
        o_dout_b <= r_mem[i_addr_b];
    end

endmodule

// File: rtl/fb_write_pipe.sv
// -----------------------------------------------------------------------------
// fb_write_pipe
// Back-bank write pipeline.
//   DEPTH_TEST=0 : accept at T, commit at T+1.
//   DEPTH_TEST=1 : accept + back-bank read at T, compare at T+1, commit at T+2
//                  only if new data < stored data (unsigned, strict).
// Out-of-range addresses are accepted and silently dropped.
// Ports:
//   i_accept/i_addr/i_data   : accepted write (valid && ready)
//   o_rd_addr / i_rd_data    : back-bank read port (depth mode)
//   o_commit/_addr/_data     : back-bank write
//   o_empty                  : no write in flight
// -----------------------------------------------------------------------------
module fb_write_pipe #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FB_SIZE    = 16,
    parameter int DEPTH_TEST = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_accept,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_commit,
    output logic [ADDR_WIDTH-1:0] o_commit_addr,
    output logic [DATA_WIDTH-1:0] o_commit_data,
    output logic                  o_empty
);

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } fb_wr_stage_t;

    localparam logic [ADDR_WIDTH:0] LP_SIZE = (ADDR_WIDTH + 1)'(FB_SIZE);

    fb_wr_stage_t r_s1;
    logic         w_in_range;

    assign w_in_range = ({1'b0, i_addr} < LP_SIZE);
    // The read is issued in the accept cycle so the data lands with stage 1.
    assign o_rd_addr  = i_addr;

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values; blocking assignments here would create ordering races.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1 <= '0;
        end else begin
            r_s1.valid <= i_accept && w_in_range;
            r_s1.addr  <= i_addr;
            r_s1.data  <= i_data;
        end
    end

    if (DEPTH_TEST != 0) begin : g_depth
        fb_wr_stage_t          r_s2;  // committing this cycle
        fb_wr_stage_t          r_s3;  // committed at the previous edge
        logic [DATA_WIDTH-1:0] w_stored;

        // Stage 1's RAM read predates the writes held in s2 and s3 (the RAM
        // is read-first), so the newest matching of those overrides it.
        // NOTE: default assigned first so no path leaves w_stored unassigned,
        // which would otherwise infer a latch.
        always_comb begin
            w_stored = i_rd_data;
            if (r_s2.valid && (r_s2.addr == r_s1.addr)) begin
                w_stored = r_s2.data;
            end else if (r_s3.valid && (r_s3.addr == r_s1.addr)) begin
                w_stored = r_s3.data;
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_s2 <= '0;
                r_s3 <= '0;
            end else begin
                r_s2.valid <= r_s1.valid && (r_s1.data < w_stored);
                r_s2.addr  <= r_s1.addr;
                r_s2.data  <= r_s1.data;
                r_s3       <= r_s2;
            end
        end

        assign o_commit      = r_s2.valid;
        assign o_commit_addr = r_s2.addr;
        assign o_commit_data = r_s2.data;
        assign o_empty       = !r_s1.valid && !r_s2.valid;
    end else begin : g_plain
        logic w_unused_rd;
        assign w_unused_rd   = ^i_rd_data;
        assign o_commit      = r_s1.valid;
        assign o_commit_addr = r_s1.addr;
        assign o_commit_data = r_s1.data;
        assign o_empty       = !r_s1.valid;
    end

endmodule

// File: rtl/double_framebuffer.sv
// -----------------------------------------------------------------------------
// double_framebuffer
// Two equal banks: the rasteriser writes the back bank, the display reads the
// front bank. A swap exchanges them once in-flight writes have drained; the
// new back bank is then optionally cleared (AUTO_CLEAR or a pending clear).
// Ports:
//   clk, rstn                          : clock, async active-low reset
//   write_valid/ready/addr/data        : back-bank write handshake
//   read_addr -> read_data             : front-bank read, 1-cycle latency
//   clear_req, clear_value             : clear back bank (value sampled at start)
//   swap_req, swap_done                : swap request / 1-cycle done pulse
//   front_sel                          : current front bank index
//   ready                              : idle, nothing pending, pipeline empty
// -----------------------------------------------------------------------------
module double_framebuffer
    import framebuffer_pkg::*;
#(
    parameter int    FB_WIDTH   = 160,
    parameter int    FB_HEIGHT  = 120,
    parameter int    DATA_WIDTH = 12,
    parameter int    DEPTH_TEST = 0,
    parameter int    AUTO_CLEAR = 1,
    parameter string FILE       = "",
    parameter int    ADDR_WIDTH = $clog2(FB_WIDTH * FB_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  write_valid,
    output logic                  write_ready,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] read_data,
    input  logic                  clear_req,
    input  logic [DATA_WIDTH-1:0] clear_value,
    input  logic                  swap_req,
    output logic                  swap_done,
    output logic                  front_sel,
    output logic                  ready
);

    localparam int                    FB_SIZE       = FB_WIDTH * FB_HEIGHT;
    localparam logic [ADDR_WIDTH-1:0] LP_CLEAR_LAST = ADDR_WIDTH'(FB_SIZE - 1);

    fb_state_t             r_state, w_state_nxt;
    logic                  r_front_sel, w_front_sel_nxt;
    logic                  r_swap_pending, w_swap_pending_nxt;
    logic                  r_clear_pending, w_clear_pending_nxt;
    logic                  r_swap_done, w_swap_done_nxt;
    logic [ADDR_WIDTH-1:0] r_clear_cnt, w_clear_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_clear_value, w_clear_value_nxt;
    logic                  r_rd_sel;

    logic                  w_accept, w_pipe_empty, w_commit;
    logic [ADDR_WIDTH-1:0] w_commit_addr, w_pipe_rd_addr, w_back_addr;
    logic [DATA_WIDTH-1:0] w_commit_data, w_back_din, w_back_dout;
    logic                  w_back_we;
    logic [DATA_WIDTH-1:0] w_bank_dout [2];

    assign write_ready = (r_state == FB_IDLE) && !r_swap_pending && !r_clear_pending;
    assign ready       = write_ready && w_pipe_empty;
    assign w_accept    = write_valid && write_ready;
    assign swap_done   = r_swap_done;
    assign front_sel   = r_front_sel;

    fb_write_pipe #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .FB_SIZE    (FB_SIZE),
        .DEPTH_TEST (DEPTH_TEST)
    ) u_pipe (
        .clk           (clk),
        .rstn          (rstn),
        .i_accept      (w_accept),
        .i_addr        (write_addr),
        .i_data        (write_data),
        .o_rd_addr     (w_pipe_rd_addr),
        .i_rd_data     (w_back_dout),
        .o_commit      (w_commit),
        .o_commit_addr (w_commit_addr),
        .o_commit_data (w_commit_data),
        .o_empty       (w_pipe_empty)
    );

    always_comb begin
        w_state_nxt         = r_state;
        w_front_sel_nxt     = r_front_sel;
        w_swap_pending_nxt  = r_swap_pending | swap_req;
        w_clear_pending_nxt = r_clear_pending;
        w_swap_done_nxt     = 1'b0;
        w_clear_cnt_nxt     = r_clear_cnt;
        w_clear_value_nxt   = r_clear_value;
        w_back_we           = 1'b0;
        w_back_addr         = w_commit_addr;
        w_back_din          = w_commit_data;

        case (r_state)
            FB_IDLE: begin
                w_back_we           = w_commit;
                w_clear_pending_nxt = r_clear_pending | clear_req;
                if (r_swap_pending) begin
                    if (w_pipe_empty) begin
                        w_front_sel_nxt    = ~r_front_sel;
                        w_swap_done_nxt    = 1'b1;
                        w_swap_pending_nxt = swap_req;
                        // Clear runs on the bank that has just become back.
                        if ((AUTO_CLEAR != 0) || r_clear_pending) begin
                            w_state_nxt         = FB_CLEARING;
                            w_clear_cnt_nxt     = '0;
                            w_clear_value_nxt   = clear_value;
                            w_clear_pending_nxt = 1'b0;
                        end
                    end
                end else if (r_clear_pending && w_pipe_empty) begin
                    w_state_nxt         = FB_CLEARING;
                    w_clear_cnt_nxt     = '0;
                    w_clear_value_nxt   = clear_value;
                    w_clear_pending_nxt = 1'b0;
                end
            end
            FB_CLEARING: begin
                // clear_req is not latched here: a clear never restarts itself.
                w_back_we       = 1'b1;
                w_back_addr     = r_clear_cnt;
                w_back_din      = r_clear_value;
                w_clear_cnt_nxt = r_clear_cnt + ADDR_WIDTH'(1);
                if (r_clear_cnt == LP_CLEAR_LAST) begin
                    w_state_nxt = FB_IDLE;
                end
            end
            default: w_state_nxt = FB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state         <= FB_IDLE;
            r_front_sel     <= 1'b0;
            r_swap_pending  <= 1'b0;
            r_clear_pending <= 1'b0;
            r_swap_done     <= 1'b0;
            r_clear_cnt     <= '0;
            r_clear_value   <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_front_sel     <= w_front_sel_nxt;
            r_swap_pending  <= w_swap_pending_nxt;
            r_clear_pending <= w_clear_pending_nxt;
            r_swap_done     <= w_swap_done_nxt;
            r_clear_cnt     <= w_clear_cnt_nxt;
            r_clear_value   <= w_clear_value_nxt;
        end
    end

    // Output mux follows the bank that was front when read_addr was sampled;
    // read_data is unreset datapath, so its select needs no reset either.
    always_ff @(posedge clk) begin
        r_rd_sel <= r_front_sel;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic w_is_front;
        assign w_is_front = (r_front_sel == 1'(b));

        bram_dp #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (FB_SIZE),
            .INIT_FILE  (FILE)
        ) u_bram (
            .i_clk_a  (clk),
            .i_we_a   (w_back_we && !w_is_front),
            .i_addr_a (w_back_addr),
            .i_din_a  (w_back_din),
            .i_clk_b  (clk),
            .i_addr_b (w_is_front ? read_addr : w_pipe_rd_addr),
            .o_dout_b (w_bank_dout[b])
        );
    end

    assign read_data   = w_bank_dout[r_rd_sel];
    assign w_back_dout = w_bank_dout[~r_front_sel];

endmodule

// File: tb/tb_double_framebuffer.sv
module tb_double_framebuffer;

    localparam int DW   = 8;
    localparam int AW_A = 5;   // widened so address 16 is expressible
    localparam int AW_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: plain write, no auto clear
    logic            rstn_a, write_valid_a, write_ready_a, clear_req_a;
    logic            swap_req_a, swap_done_a, front_sel_a, ready_a;
    logic [AW_A-1:0] write_addr_a, read_addr_a;
    logic [DW-1:0]   write_data_a, read_data_a, clear_value_a;

    // Instance B: depth test, auto clear
    logic            rstn_b, write_valid_b, write_ready_b, clear_req_b;
    logic            swap_req_b, swap_done_b, front_sel_b, ready_b;
    logic [AW_B-1:0] write_addr_b, read_addr_b;
    logic [DW-1:0]   write_data_b, read_data_b, clear_value_b;

    double_framebuffer #(
        .FB_WIDTH(4), .FB_HEIGHT(4), .DATA_WIDTH(DW),
        .DEPTH_TEST(0), .AUTO_CLEAR(0), .FILE(""), .ADDR_WIDTH(AW_A)
    ) u_a (
        .clk(clk), .rstn(rstn_a),
        .write_valid(write_valid_a), .write_ready(write_ready_a),
        .write_addr(write_addr_a), .write_data(write_data_a),
        .read_addr(read_addr_a), .read_data(read_data_a),
        .clear_req(clear_req_a), .clear_value(clear_value_a),
        .swap_req(swap_req_a), .swap_done(swap_done_a),
        .front_sel(front_sel_a), .ready(ready_a)
    );

    double_framebuffer #(
        .FB_WIDTH(4), .FB_HEIGHT(4), .DATA_WIDTH(DW),
        .DEPTH_TEST(1), .AUTO_CLEAR(1), .FILE("")
    ) u_b (
        .clk(clk), .rstn(rstn_b),
        .write_valid(write_valid_b), .write_ready(write_ready_b),
        .write_addr(write_addr_b), .write_data(write_data_b),
        .read_addr(read_addr_b), .read_data(read_data_b),
        .clear_req(clear_req_b), .clear_value(clear_value_b),
        .swap_req(swap_req_b), .swap_done(swap_done_b),
        .front_sel(front_sel_b), .ready(ready_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Back-bank commits of instance B, counted while enabled.
    bit count_commits = 1'b0;
    int commits_b     = 0;
    always @(negedge clk) begin
        if (count_commits && u_b.u_pipe.o_commit) commits_b++;
    end

    typedef struct { logic [AW_A-1:0] addr; logic [DW-1:0] data; } wr_vec_t;
    typedef struct { logic [AW_A-1:0] addr; logic [DW-1:0] exp;  } rd_vec_t;
    wr_vec_t wr_tbl [6];
    rd_vec_t rd_tbl [16];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit clean;

        // Last entry goes out together with swap_req; 16 is out of range.
        wr_tbl[0] = '{5'd0,  8'h11};
        wr_tbl[1] = '{5'd9,  8'hA5};
        wr_tbl[2] = '{5'd15, 8'hEE};
        wr_tbl[3] = '{5'd16, 8'h77};
        wr_tbl[4] = '{5'd9,  8'hB6};
        wr_tbl[5] = '{5'd5,  8'h3C};
        rd_tbl[0]  = '{5'd0,  8'h11};  rd_tbl[1]  = '{5'd1,  8'h00};
        rd_tbl[2]  = '{5'd2,  8'h00};  rd_tbl[3]  = '{5'd3,  8'h00};
        rd_tbl[4]  = '{5'd4,  8'h00};  rd_tbl[5]  = '{5'd5,  8'h3C};
        rd_tbl[6]  = '{5'd6,  8'h00};  rd_tbl[7]  = '{5'd7,  8'h00};
        rd_tbl[8]  = '{5'd8,  8'h00};  rd_tbl[9]  = '{5'd9,  8'hB6};
        rd_tbl[10] = '{5'd10, 8'h00};  rd_tbl[11] = '{5'd11, 8'h00};
        rd_tbl[12] = '{5'd12, 8'h00};  rd_tbl[13] = '{5'd13, 8'h00};
        rd_tbl[14] = '{5'd14, 8'h00};  rd_tbl[15] = '{5'd15, 8'hEE};

        rstn_a = 1'b0; write_valid_a = 1'b0; write_addr_a = '0; write_data_a = '0;
        read_addr_a = '0; clear_req_a = 1'b0; clear_value_a = '0; swap_req_a = 1'b0;
        rstn_b = 1'b0; write_valid_b = 1'b0; write_addr_b = '0; write_data_b = '0;
        read_addr_b = '0; clear_req_b = 1'b0; clear_value_b = '0; swap_req_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn_a = 1'b1;
        rstn_b = 1'b1;
        step();

        // ---------------- reset state ----------------
        check("a_rst_front_sel",   32'(front_sel_a),   0);
        check("a_rst_ready",       32'(ready_a),       1);
        check("a_rst_write_ready", 32'(write_ready_a), 1);
        check("a_rst_swap_done",   32'(swap_done_a),   0);
        check("b_rst_front_sel",   32'(front_sel_b),   0);
        check("b_rst_ready",       32'(ready_b),       1);

        // ---------------- A: explicit clear of back bank to 0 ----------------
        clear_value_a = 8'h00;
        clear_req_a   = 1'b1;
        step();
        clear_req_a = 1'b0;
        check("a_clear_busy", 32'(write_ready_a), 0);
        n = 0;
        while (!ready_a && n < 50) begin step(); n++; end
        check("a_clear_done_timeout", 32'(ready_a), 1);

        // ---------------- A: table writes, swap with the last ----------------
        for (int i = 0; i < 6; i++) begin
            check($sformatf("a_wr_accept_%0d", i), 32'(write_ready_a), 1);
            write_valid_a = 1'b1;
            write_addr_a  = wr_tbl[i].addr;
            write_data_a  = wr_tbl[i].data;
            swap_req_a    = (i == 5);
            step();
        end
        write_valid_a = 1'b0;
        swap_req_a    = 1'b0;
        n = 1;
        while (!swap_done_a && n < 50) begin step(); n++; end
        check("a_swap_latency", 32'(n), 3);
        check("a_swap_front_sel", 32'(front_sel_a), 1);
        step();
        check("a_swap_done_pulse", 32'(swap_done_a), 0);
        check("a_no_auto_clear", 32'(write_ready_a), 1);

        for (int i = 0; i < 16; i++) begin
            read_addr_a = rd_tbl[i].addr;
            step();
            check($sformatf("a_rd_%0d", i), 32'(read_data_a), 32'(rd_tbl[i].exp));
        end

        // ---------------- B: auto clear after swap ----------------
        clear_value_b = 8'hFF;
        for (int s = 0; s < 2; s++) begin
            swap_req_b = 1'b1;
            step();
            swap_req_b = 1'b0;
            n = 0;
            while (!swap_done_b && n < 50) begin step(); n++; end
            check($sformatf("b_swap%0d_latency", s), 32'(n), 1);
            check($sformatf("b_swap%0d_front", s), 32'(front_sel_b), (s == 0) ? 1 : 0);
            n = 0;
            while (!write_ready_b && n < 50) begin step(); n++; end
            check($sformatf("b_swap%0d_clear_cycles", s), 32'(n), 16);
        end
        for (int i = 0; i < 16; i++) begin
            read_addr_b = 4'(i);
            step();
            check($sformatf("b_ff_rd_%0d", i), 32'(read_data_b), 'hFF);
        end

        // ---------------- B: depth test, back-to-back same address ----------------
        count_commits = 1'b1;
        write_addr_b  = 4'd3;
        write_valid_b = 1'b1;
        write_data_b = 8'h80; step();
        write_data_b = 8'h90; step();
        write_data_b = 8'h40; step();
        write_data_b = 8'h40; step();
        write_valid_b = 1'b0;
        n = 0;
        while (!ready_b && n < 20) begin step(); n++; end
        check("b_depth_drain_timeout", 32'(ready_b), 1);
        step();
        count_commits = 1'b0;
        check("b_depth_commits", 32'(commits_b), 2);

        // ---------------- B: swap, then swap_req at clear cycle 7 ----------------
        clear_value_b = 8'h5A;
        swap_req_b = 1'b1;
        step();
        swap_req_b = 1'b0;
        n = 0;
        while (!swap_done_b && n < 50) begin step(); n++; end
        check("b_swap3_latency", 32'(n), 1);
        n = 0;
        while (n < 40) begin
            step();
            n++;
            if (n == 2) read_addr_b = 4'd3;
            if (n == 3) begin
                check("b_depth_stored", 32'(read_data_b), 'h40);
                read_addr_b = 4'd2;
            end
            if (n == 4) check("b_depth_other", 32'(read_data_b), 'hFF);
            swap_req_b = (n == 7);
            if (swap_done_b) break;
        end
        swap_req_b = 1'b0;
        check("b_midclear_swap_cycle", 32'(n), 17);
        check("b_midclear_front", 32'(front_sel_b), 0);
        n = 0;
        while (!write_ready_b && n < 50) begin step(); n++; end
        check("b_midclear_clear_cycles", 32'(n), 16);
        for (int i = 0; i < 16; i += 7) begin
            read_addr_b = 4'(i);
            step();
            check($sformatf("b_cleared_rd_%0d", i), 32'(read_data_b), 'h5A);
        end

        // ---------------- B: reset in the middle of a clear ----------------
        swap_req_b = 1'b1;
        step();
        swap_req_b = 1'b0;
        n = 0;
        while (!swap_done_b && n < 50) begin step(); n++; end
        check("b_swap5_front", 32'(front_sel_b), 1);
        repeat (5) step();
        swap_req_b  = 1'b1;
        clear_req_b = 1'b1;
        step();
        swap_req_b  = 1'b0;
        clear_req_b = 1'b0;
        check("b_pre_reset_busy", 32'(write_ready_b), 0);
        #2;
        rstn_b = 1'b0;
        #1;
        check("b_async_rst_front_sel",   32'(front_sel_b),   0);
        check("b_async_rst_swap_done",   32'(swap_done_b),   0);
        check("b_async_rst_write_ready", 32'(write_ready_b), 1);
        check("b_async_rst_ready",       32'(ready_b),       1);
        @(negedge clk);
        rstn_b = 1'b1;
        clean = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (swap_done_b || front_sel_b || !ready_b || !write_ready_b) clean = 1'b0;
        end
        check("b_post_reset_idle", 32'(clean), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
